// File: rtl/mips_lsu.sv
// Load/store unit: aligns byte/half/word core accesses onto a little-endian 32-bit data bus,
// runs the req/ack handshake with data memory and reports AdEL/AdES/DBE faults.
module mips_lsu #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        adel,
  output logic        ades,
  output logic        dbe,
  output logic [31:0] bad_addr,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_write_en,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ack,
  input  logic        mem_excpt
);

  typedef enum logic [1:0] {StIdle, StWait, StResp, StErr} state_e;
  typedef enum logic [1:0] {ErrNone, ErrAdel, ErrAdes, ErrDbe} err_e;

  state_e      state_q, state_d;
  err_e        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  logic        req_store_q;
  logic        req_unsigned_q;
  logic [1:0]  req_size_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;

  logic        req_fault;
  logic        timeout;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [3:0]  lane_we;
  logic [31:0] lane_data;

  assign req_fault = (req_size == 2'd3) ||
                     (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'd0);

  assign timeout = (cnt_q == 8'(TIMEOUT - 1));

  // Load extraction from the lane selected by the latched address.
  assign ld_byte = mem_data_out[{req_addr_q[1:0], 3'b000} +: 8];
  assign ld_half = req_addr_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];

  always_comb begin
    case (req_size_q)
      2'd0:    load_data = {{24{~req_unsigned_q & ld_byte[7]}}, ld_byte};
      2'd1:    load_data = {{16{~req_unsigned_q & ld_half[15]}}, ld_half};
      default: load_data = mem_data_out;
    endcase
  end

  // Store data is replicated across lanes; the write mask picks the lanes that land.
  always_comb begin
    case (req_size_q)
      2'd0: begin
        lane_we   = 4'b0001 << req_addr_q[1:0];
        lane_data = {4{req_wdata_q[7:0]}};
      end
      2'd1: begin
        lane_we   = req_addr_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata_q[15:0]}};
      end
      default: begin
        lane_we   = 4'b1111;
        lane_data = req_wdata_q;
      end
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= StIdle;
      err_q          <= ErrNone;
      cnt_q          <= '0;
      rdata_q        <= '0;
      bad_addr_q     <= '0;
      req_store_q    <= 1'b0;
      req_unsigned_q <= 1'b0;
      req_size_q     <= '0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      bad_addr_q <= bad_addr_d;
      if (state_q == StIdle && req_valid && !req_fault) begin
        req_store_q    <= req_store;
        req_unsigned_q <= req_unsigned;
        req_size_q     <= req_size;
        req_addr_q     <= req_addr;
        req_wdata_q    <= req_wdata;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) state_d = req_fault ? StErr : StWait;
      end
      StWait: begin
        if (mem_excpt)    state_d = StErr;
        else if (mem_ack) state_d = StResp;
        else if (timeout) state_d = StErr;
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: wait counter, fault kind/address, captured load data.
  always_comb begin
    err_d      = err_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    bad_addr_d = bad_addr_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req_valid && req_fault) begin
          err_d      = req_store ? ErrAdes : ErrAdel;
          bad_addr_d = req_addr;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_excpt || (!mem_ack && timeout)) begin
          err_d      = ErrDbe;
          bad_addr_d = req_addr_q;
        end else if (mem_ack) begin
          rdata_d = req_store_q ? '0 : load_data;
        end
      end
      default: ;
    endcase
  end

  // Outputs. stall is gated by reset so a held req_valid cannot stall the core in reset.
  always_comb begin
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_write_en = '0;
    resp_valid   = 1'b0;
    adel         = 1'b0;
    ades         = 1'b0;
    dbe          = 1'b0;
    case (state_q)
      StIdle: stall = req_valid & rst_b;
      StWait: begin
        stall        = 1'b1;
        mem_req      = 1'b1;
        mem_write_en = req_store_q ? lane_we : 4'b0000;
      end
      StResp: resp_valid = 1'b1;
      StErr: begin
        adel = (err_q == ErrAdel);
        ades = (err_q == ErrAdes);
        dbe  = (err_q == ErrDbe);
      end
      default: ;
    endcase
  end

  assign mem_addr    = req_addr_q[31:2];
  assign mem_data_in = lane_data;
  assign resp_rdata  = rdata_q;
  assign bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Bench for mips_lsu: transaction-level reference model drives random ops and a per-cycle
// compare process checks every output; literal checks pin the model on known vectors.
module tb_mips_lsu;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall, resp_valid, adel, ades, dbe, mem_req;
  logic [31:0] resp_rdata, bad_addr, mem_data_in;
  logic [29:0] mem_addr;
  logic [3:0]  mem_write_en;
  logic [31:0] mem_data_out = '0;
  logic        mem_ack = 1'b0;
  logic        mem_excpt = 1'b0;

  mips_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_valid    (req_valid),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .adel         (adel),
    .ades         (ades),
    .dbe          (dbe),
    .bad_addr     (bad_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .mem_ack      (mem_ack),
    .mem_excpt    (mem_excpt)
  );

  always #5 clk = ~clk;

  // Expected per-cycle outputs, written only by the stimulus process.
  bit          chk_en = 1'b0;
  bit          exp_stall, exp_mem_req, exp_resp, exp_adel, exp_ades, exp_dbe, exp_chk_mdata;
  logic [3:0]  exp_we = '0;
  logic [29:0] exp_maddr = '0;
  logic [31:0] exp_mdata = '0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] exp_bad = '0;

  // Literal-check mailbox: stimulus bumps lit_seq, compare process consumes it.
  string       lit_name = "";
  logic [31:0] lit_act = '0;
  logic [31:0] lit_exp = '0;
  int          lit_seq = 0;
  int          lit_done = 0;

  // Counters and observations, written only by the compare process.
  int          checks = 0;
  int          errors = 0;
  int          n_stall = 0, n_mreq = 0, n_resp = 0, n_exc = 0;
  logic [3:0]  o_we = '0;
  logic [31:0] o_mdata = '0, o_rdata = '0, o_bad = '0;
  logic [29:0] o_maddr = '0;
  logic [2:0]  o_exc = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", 32'(stall), 32'(exp_stall));
      cmp("mem_req", 32'(mem_req), 32'(exp_mem_req));
      cmp("mem_write_en", 32'(mem_write_en), 32'(exp_we));
      cmp("resp_valid", 32'(resp_valid), 32'(exp_resp));
      cmp("adel", 32'(adel), 32'(exp_adel));
      cmp("ades", 32'(ades), 32'(exp_ades));
      cmp("dbe", 32'(dbe), 32'(exp_dbe));
      cmp("resp_rdata", resp_rdata, exp_rdata);
      if (exp_adel || exp_ades || exp_dbe) cmp("bad_addr", bad_addr, exp_bad);
      if (exp_mem_req) cmp("mem_addr", 32'(mem_addr), 32'(exp_maddr));
      if (exp_mem_req && exp_chk_mdata) cmp("mem_data_in", mem_data_in, exp_mdata);
    end
    if (stall) n_stall++;
    if (mem_req) begin
      n_mreq++;
      o_we    = mem_write_en;
      o_mdata = mem_data_in;
      o_maddr = mem_addr;
    end
    if (resp_valid) begin
      n_resp++;
      o_rdata = resp_rdata;
    end
    if (adel || ades || dbe) begin
      n_exc++;
      o_exc = {adel, ades, dbe};
      o_bad = bad_addr;
    end
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      cmp(lit_name, lit_act, lit_exp);
    end
  end

  int s_stall, s_mreq, s_resp, s_exc;

  task automatic snap();
    s_stall = n_stall;
    s_mreq  = n_mreq;
    s_resp  = n_resp;
    s_exc   = n_exc;
  endtask

  // Queue a literal comparison; returns one cycle later at posedge+1.
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_name = name;
    lit_act  = act;
    lit_exp  = exp;
    lit_seq++;
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    exp_stall = 0; exp_mem_req = 0; exp_resp = 0;
    exp_adel = 0; exp_ades = 0; exp_dbe = 0; exp_chk_mdata = 0;
    exp_we = '0;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      req_valid = 0;
      req_addr  = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      set_idle();
      @(posedge clk); #1;
    end
  endtask

  // One complete request. lat = WAIT cycle carrying mem_ack (0 = never), exc = WAIT cycle
  // carrying mem_excpt (0 = never). Called and returns at posedge+1.
  task automatic do_op(input bit st, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] mword, input int lat,
                       input int exc);
    bit fault, err;
    int off, n;
    logic [3:0] we;
    logic [31:0] md, ld;
    off   = int'(addr[1:0]);
    fault = (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
    if (sz == 0) begin
      we = 4'b0001 << off;
      md = {4{wd[7:0]}};
      ld = (mword >> (8 * off)) & 32'hff;
      if (!uns && ld[7]) ld = ld | 32'hffffff00;
    end else if (sz == 1) begin
      we = (off >= 2) ? 4'b1100 : 4'b0011;
      md = {2{wd[15:0]}};
      ld = (mword >> ((off >= 2) ? 16 : 0)) & 32'hffff;
      if (!uns && ld[15]) ld = ld | 32'hffff0000;
    end else begin
      we = 4'b1111;
      md = wd;
      ld = mword;
    end
    if (st) ld = '0;

    req_valid = 1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    mem_ack = 0; mem_excpt = 0;
    set_idle();
    exp_stall = 1;
    @(posedge clk); #1;
    if (fault) begin
      req_valid = 0;
      set_idle();
      exp_adel = !st; exp_ades = st; exp_bad = addr;
      @(posedge clk); #1;
    end else begin
      n = 0;
      err = 0;
      forever begin
        n++;
        mem_excpt    = (n == exc);
        mem_ack      = (n == lat);
        mem_data_out = mem_ack ? mword : $urandom;
        set_idle();
        exp_stall = 1; exp_mem_req = 1; exp_we = st ? we : 4'b0000;
        exp_maddr = addr[31:2]; exp_mdata = md; exp_chk_mdata = st;
        @(posedge clk); #1;
        if (mem_excpt || mem_ack || n == TIMEOUT) begin
          err = mem_excpt || !mem_ack;
          break;
        end
      end
      mem_ack = 0; mem_excpt = 0; req_valid = 0;
      mem_data_out = $urandom;
      set_idle();
      if (err) begin
        exp_dbe = 1; exp_bad = addr;
      end else begin
        exp_resp = 1; exp_rdata = ld;
      end
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by 2000000");
    $fatal(1);
  end

  initial begin
    bit st, uns;
    logic [1:0] sz;
    logic [31:0] addr;
    int r, lat, exc;

    // Reset state, with req_valid held high to show stall stays low in reset.
    set_idle();
    req_valid = 1;
    @(posedge clk); #1;
    lit("rst0_stall", 32'(stall), 32'd0);
    lit("rst0_mem_req", 32'(mem_req), 32'd0);
    lit("rst0_resp_valid", 32'(resp_valid), 32'd0);
    lit("rst0_resp_rdata", resp_rdata, 32'd0);
    lit("rst0_bad_addr", bad_addr, 32'd0);
    lit("rst0_exc", 32'({adel, ades, dbe}), 32'd0);
    lit("rst0_mem_write_en", 32'(mem_write_en), 32'd0);
    req_valid = 0;
    rst_b = 1;
    @(posedge clk); #1;
    chk_en = 1;

    snap();
    do_op(0, 2, 0, 32'h1000, 32'h0, 32'hDEADBEEF, 2, 0);
    lit("lw_rdata", o_rdata, 32'hDEADBEEF);
    lit("lw_stall_cycles", 32'(n_stall - s_stall), 32'd3);

    do_op(0, 0, 0, 32'h1003, 32'h0, 32'h80FFFFFF, 1, 0);
    lit("lb_rdata", o_rdata, 32'hFFFFFF80);
    do_op(0, 0, 1, 32'h1003, 32'h0, 32'h80FFFFFF, 3, 0);
    lit("lbu_rdata", o_rdata, 32'h00000080);
    do_op(0, 1, 0, 32'h1002, 32'h0, 32'h80FFFFFF, 1, 0);
    lit("lh_rdata", o_rdata, 32'hFFFF80FF);

    do_op(1, 0, 0, 32'h2001, 32'h123456AB, 32'h0, 1, 0);
    lit("sb_we", 32'(o_we), 32'b0010);
    lit("sb_data", o_mdata, 32'hABABABAB);
    lit("sb_maddr", 32'(o_maddr), 32'h800);
    lit("sb_rdata_zero", o_rdata, 32'h0);

    do_op(1, 1, 0, 32'h2002, 32'h0000CAFE, 32'h0, 2, 0);
    lit("sh_we", 32'(o_we), 32'b1100);
    lit("sh_data", o_mdata, 32'hCAFECAFE);

    snap();
    do_op(1, 1, 0, 32'h2001, 32'h0000CAFE, 32'h0, 1, 0);
    lit("sh_mis_exc", 32'(o_exc), 32'b010);
    lit("sh_mis_bad_addr", o_bad, 32'h2001);
    lit("sh_mis_no_mem_req", 32'(n_mreq - s_mreq), 32'd0);

    snap();
    do_op(0, 2, 0, 32'h4000, 32'h0, 32'h11111111, 1, 1);
    lit("excpt_ack_exc", 32'(o_exc), 32'b001);
    lit("excpt_ack_no_resp", 32'(n_resp - s_resp), 32'd0);

    snap();
    do_op(0, 2, 0, 32'h5000, 32'h0, 32'h0, 0, 0);
    lit("timeout_exc", 32'(o_exc), 32'b001);
    lit("timeout_stall_cycles", 32'(n_stall - s_stall), 32'(TIMEOUT + 1));

    // Reset in the middle of a WAIT: outputs drop without waiting for a clock edge.
    req_valid = 1; req_store = 0; req_size = 2; req_unsigned = 0; req_addr = 32'h3000;
    set_idle();
    exp_stall = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      exp_stall = 1; exp_mem_req = 1; exp_maddr = 30'h0C00;
      mem_data_out = $urandom;
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    #1;
    chk_en = 0;
    rst_b = 0;
    #1;
    lit("rstw_mem_req", 32'(mem_req), 32'd0);
    lit("rstw_stall", 32'(stall), 32'd0);
    lit("rstw_resp_rdata", resp_rdata, 32'd0);
    req_valid = 0;
    exp_rdata = '0;
    set_idle();
    rst_b = 1;
    @(posedge clk); #1;
    chk_en = 1;
    do_op(0, 2, 0, 32'h3004, 32'h0, 32'h13579BDF, 1, 0);
    lit("rstw_lw_rdata", o_rdata, 32'h13579BDF);

    for (int i = 0; i < 250; i++) begin
      st   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd2) addr[1:0] = 2'b00;
        if (sz == 2'd1) addr[0] = 1'b0;
      end
      r = $urandom_range(0, 39);
      if (r == 0) begin
        lat = 0; exc = 0;
      end else if (r < 6) begin
        lat = $urandom_range(1, 4); exc = $urandom_range(1, 3);
      end else begin
        lat = $urandom_range(1, 5); exc = 0;
      end
      do_op(st, sz, uns, addr, $urandom, $urandom, lat, exc);
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
